// File: rtl/conv_window_ctrl_if.sv
// Handshake bundle for the 3x3 convolution window controller.
// The slave side is the controller; the master side is the surrounding
// pixel source / window sink that drives start, in_valid and out_ready.
interface conv_window_ctrl_if;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        shift_en;
  logic        out_ready;
  logic        win_valid;
  logic [11:0] win_x;
  logic [11:0] win_y;
  logic        busy;
  logic        frame_done;

  modport slave (
    input  start, in_valid, out_ready,
    output in_ready, shift_en, win_valid, win_x, win_y, busy, frame_done
  );

  modport master (
    output start, in_valid, out_ready,
    input  in_ready, shift_en, win_valid, win_x, win_y, busy, frame_done
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// 3x3 sliding-window controller. Tracks the raster position of incoming
// pixels, strobes the row-buffer chain on every accepted pixel and flags
// each position where the buffers hold a complete 3x3 neighbourhood.
// Windows are held under downstream back-pressure, and pixel intake stalls
// while a window is waiting, so no window is ever lost or overwritten.
module conv_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
) (
  input logic               clk,
  input logic               reset,
  conv_window_ctrl_if.slave win_if
);

  localparam int            CW       = 12;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic [CW-1:0] win_x_q, win_x_d;
  logic [CW-1:0] win_y_q, win_y_d;

  logic in_ready;
  logic busy;
  logic frame_done;
  logic accept;
  logic at_col_last;
  logic at_row_last;
  logic new_win;
  logic frame_start;

  // A pixel moves into the row buffers only when both sides agree.
  assign accept      = win_if.in_valid & in_ready;
  assign at_col_last = (col_q == COL_LAST);
  assign at_row_last = (row_q == ROW_LAST);
  // The first two rows and columns only fill the buffers; a full
  // neighbourhood exists once the pixel at col>=2, row>=2 arrives.
  assign new_win     = accept & (col_q >= TWO) & (row_q >= TWO);
  assign frame_start = (state_q == S_IDLE) & win_if.start;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: prime two rows, run the rest, drain the last window.
  always_comb begin
    // NOTE: a default before the case keeps this block purely combinational;
    // any path that left state_d unassigned would infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_if.start) state_d = S_PRIME;
      S_PRIME: if (accept && at_col_last && (row_q == ONE)) state_d = S_RUN;
      S_RUN:   if (accept && at_col_last && at_row_last) state_d = S_DRAIN;
      S_DRAIN: if (!win_valid_q || win_if.out_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs: intake enable, busy flag and end-of-frame pulse.
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE:  busy       = 1'b0;
      S_PRIME: in_ready   = 1'b1;
      S_RUN:   in_ready   = !win_valid_q || win_if.out_ready;
      S_DONE:  frame_done = 1'b1;
      default: ;
    endcase
  end

  // Raster position: clears on frame start, advances on every accepted pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (frame_start) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (at_col_last) begin
        col_d = '0;
        // The last pixel of the frame folds back to the origin rather than
        // stepping past the final row.
        row_d = at_row_last ? '0 : row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  // Window register: a fresh window replaces the current one back-to-back;
  // otherwise a consumed window clears and an unconsumed one holds.
  always_comb begin
    win_valid_d = win_valid_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    if (new_win) begin
      win_valid_d = 1'b1;
      win_x_d     = col_q - ONE;
      win_y_d     = row_q - ONE;
    end else if (win_if.out_ready) begin
      win_valid_d = 1'b0;
    end
  end

  // Position and window registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
    end
  end

  assign win_if.in_ready   = in_ready;
  assign win_if.shift_en   = accept;
  assign win_if.win_valid  = win_valid_q;
  assign win_if.win_x      = win_x_q;
  assign win_if.win_y      = win_y_q;
  assign win_if.busy       = busy;
  assign win_if.frame_done = frame_done;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: a 4x3 instance for directed frame, stall and
// mid-frame reset scenarios, and a 5x4 instance for toggled, start-spammed
// and randomized frames checked against a pixel-index reference model.
module tb_conv_window_ctrl;

  localparam int AW     = 4;
  localparam int AH     = 3;
  localparam int BW     = 5;
  localparam int BH     = 4;
  localparam int B_NPIX = BW * BH;
  localparam int B_NWIN = (BW - 2) * (BH - 2);

  typedef struct {
    int x;
    int y;
    int acc;
  } win_rec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conv_window_ctrl_if a_if ();
  conv_window_ctrl_if b_if ();

  conv_window_ctrl #(.IMG_W(AW), .IMG_H(AH)) u_a (
    .clk    (clk),
    .reset  (reset),
    .win_if (a_if.slave)
  );

  conv_window_ctrl #(.IMG_W(BW), .IMG_H(BH)) u_b (
    .clk    (clk),
    .reset  (reset),
    .win_if (b_if.slave)
  );

  // Drive one cycle of inputs at the falling edge, then settle before sampling.
  task automatic step_a(input logic st, input logic iv, input logic ordy);
    @(negedge clk);
    a_if.start     = st;
    a_if.in_valid  = iv;
    a_if.out_ready = ordy;
    #1;
  endtask

  task automatic step_b(input logic st, input logic iv, input logic ordy);
    @(negedge clk);
    b_if.start     = st;
    b_if.in_valid  = iv;
    b_if.out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    logic [28:0] va, vb;
    reset = 1'b1;
    a_if.start = 1'b0; a_if.in_valid = 1'b1; a_if.out_ready = 1'b0;
    b_if.start = 1'b0; b_if.in_valid = 1'b1; b_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    va = {a_if.in_ready, a_if.shift_en, a_if.win_valid, a_if.busy,
          a_if.frame_done, a_if.win_x, a_if.win_y};
    vb = {b_if.in_ready, b_if.shift_en, b_if.win_valid, b_if.busy,
          b_if.frame_done, b_if.win_x, b_if.win_y};
    checks++;
    if (va !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs_a: got %h want 0", va);
    end
    checks++;
    if (vb !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs_b: got %h want 0", vb);
    end
    reset = 1'b0;
    // Without start the block must sit in IDLE refusing pixels.
    repeat (3) begin
      step_a(1'b0, 1'b1, 1'b1);
      checks++;
      if ({a_if.busy, a_if.in_ready, a_if.shift_en} !== 3'b000) begin
        errors++;
        $display("FAIL idle_wait: got busy/ir/sh=%b want 000",
                 {a_if.busy, a_if.in_ready, a_if.shift_en});
      end
    end
    a_if.in_valid = 1'b0;
    b_if.in_valid = 1'b0;
  endtask

  // Full 4x3 frame with constant in_valid and out_ready.
  task automatic test_basic_frame(input string tag);
    win_rec_t wq[$];
    win_rec_t r;
    int acc = 0;
    int fd  = 0;
    step_a(1'b1, 1'b1, 1'b1);
    checks++;
    if (a_if.shift_en !== 1'b0) begin
      errors++;
      $display("FAIL %s_start_shift: got %b want 0", tag, a_if.shift_en);
    end
    for (int cyc = 0; cyc < 40 && fd == 0; cyc++) begin
      step_a(1'b0, 1'b1, 1'b1);
      if (a_if.win_valid === 1'b1) begin
        r.x = int'(a_if.win_x); r.y = int'(a_if.win_y); r.acc = acc;
        wq.push_back(r);
      end
      if (a_if.shift_en === 1'b1) acc++;
      if (a_if.frame_done === 1'b1) fd++;
    end
    checks++;
    if (acc != AW * AH) begin
      errors++;
      $display("FAIL %s_accepts: got %0d want %0d", tag, acc, AW * AH);
    end
    checks++;
    if (fd != 1) begin
      errors++;
      $display("FAIL %s_frame_done: got %0d want 1", tag, fd);
    end
    checks++;
    if (wq.size() != 2) begin
      errors++;
      $display("FAIL %s_win_cycles: got %0d want 2", tag, wq.size());
    end else begin
      checks++;
      if (wq[0].x != 1 || wq[0].y != 1 || wq[0].acc != 11) begin
        errors++;
        $display("FAIL %s_win0: got (%0d,%0d) after acc %0d want (1,1) after 11",
                 tag, wq[0].x, wq[0].y, wq[0].acc);
      end
      checks++;
      if (wq[1].x != 2 || wq[1].y != 1 || wq[1].acc != 12) begin
        errors++;
        $display("FAIL %s_win1: got (%0d,%0d) after acc %0d want (2,1) after 12",
                 tag, wq[1].x, wq[1].y, wq[1].acc);
      end
    end
    step_a(1'b0, 1'b0, 1'b0);
    checks++;
    if ({a_if.busy, a_if.frame_done} !== 2'b00) begin
      errors++;
      $display("FAIL %s_after_done: got busy/fd=%b want 00", tag,
               {a_if.busy, a_if.frame_done});
    end
  endtask

  // Downstream stalls for 5 cycles once the first window is produced.
  task automatic test_stall();
    win_rec_t hs[$];
    win_rec_t r;
    int   acc        = 0;
    int   fd         = 0;
    int   stall_left = 0;
    int   stalled    = 0;
    logic ordy;
    step_a(1'b1, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 50 && fd == 0; cyc++) begin
      ordy = (stall_left > 0) ? 1'b0 : 1'b1;
      step_a(1'b0, 1'b1, ordy);
      if (stall_left > 0) begin
        stalled++;
        checks++;
        if ({a_if.win_valid, a_if.in_ready, a_if.shift_en} !== 3'b100 ||
            a_if.win_x !== 12'd1 || a_if.win_y !== 12'd1) begin
          errors++;
          $display("FAIL stall_hold: got wv/ir/sh=%b (%0d,%0d) want 100 (1,1)",
                   {a_if.win_valid, a_if.in_ready, a_if.shift_en},
                   a_if.win_x, a_if.win_y);
        end
        stall_left--;
      end
      if (a_if.win_valid === 1'b1 && ordy) begin
        r.x = int'(a_if.win_x); r.y = int'(a_if.win_y); r.acc = acc;
        hs.push_back(r);
      end
      if (a_if.shift_en === 1'b1) begin
        acc++;
        if (acc == 11) stall_left = 5;
      end
      if (a_if.frame_done === 1'b1) fd++;
    end
    checks++;
    if (stalled != 5 || acc != AW * AH || fd != 1) begin
      errors++;
      $display("FAIL stall_totals: got stalled=%0d acc=%0d fd=%0d want 5 12 1",
               stalled, acc, fd);
    end
    checks++;
    if (hs.size() != 2) begin
      errors++;
      $display("FAIL stall_windows: got %0d handshakes want 2", hs.size());
    end else begin
      checks++;
      if (hs[0].x != 1 || hs[0].y != 1 || hs[1].x != 2 || hs[1].y != 1) begin
        errors++;
        $display("FAIL stall_order: got (%0d,%0d),(%0d,%0d) want (1,1),(2,1)",
                 hs[0].x, hs[0].y, hs[1].x, hs[1].y);
      end
    end
    step_a(1'b0, 1'b0, 1'b0);
  endtask

  // Reset mid-frame at accept 7, then a clean frame.
  task automatic test_reset_mid();
    logic [28:0] va;
    int acc = 0;
    int fd  = 0;
    step_a(1'b1, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 20 && acc < 7; cyc++) begin
      step_a(1'b0, 1'b1, 1'b1);
      if (a_if.shift_en === 1'b1) acc++;
    end
    checks++;
    if (acc != 7) begin
      errors++;
      $display("FAIL rstmid_reach7: got %0d want 7", acc);
    end
    reset = 1'b1;
    #1;
    va = {a_if.in_ready, a_if.shift_en, a_if.win_valid, a_if.busy,
          a_if.frame_done, a_if.win_x, a_if.win_y};
    checks++;
    if (va !== 29'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %h want 0", va);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step_a(1'b0, 1'b1, 1'b1);
      if (a_if.frame_done === 1'b1) fd++;
      checks++;
      if ({a_if.busy, a_if.in_ready} !== 2'b00) begin
        errors++;
        $display("FAIL rstmid_idle: got busy/ir=%b want 00",
                 {a_if.busy, a_if.in_ready});
      end
    end
    checks++;
    if (fd != 0) begin
      errors++;
      $display("FAIL rstmid_no_done: got %0d pulses want 0", fd);
    end
    test_basic_frame("post_reset");
  endtask

  // 5x4 frame against a pixel-index model. mode 0: in_valid toggles,
  // mode 1: random valid/ready/start, mode 2: start held high throughout.
  task automatic run_frame_b(input int mode, input string tag);
    win_rec_t    exp_q[$];
    win_rec_t    r;
    int          k = 0;
    int          fd = 0;
    int          wins_seen = 0;
    int          cyc = 0;
    logic        exp_wv = 1'b0;
    int          exp_x = 0;
    int          exp_y = 0;
    logic        iv, ordy, st, exp_ir, exp_acc;
    for (int y = 1; y <= BH - 2; y++)
      for (int x = 1; x <= BW - 2; x++) begin
        r.x = x; r.y = y; r.acc = 0;
        exp_q.push_back(r);
      end
    step_b(1'b1, 1'b0, 1'b0);
    while (fd == 0 && cyc < 4000) begin
      case (mode)
        0: begin iv = (cyc % 2 == 0); ordy = 1'b1; st = 1'b0; end
        1: begin
          iv   = 1'($urandom_range(0, 1));
          ordy = ($urandom_range(0, 9) < 6);
          st   = ($urandom_range(0, 7) == 0);
        end
        default: begin iv = 1'b1; ordy = 1'b1; st = 1'b1; end
      endcase
      step_b(st, iv, ordy);
      exp_ir  = (k < B_NPIX) ? (!exp_wv || ordy) : 1'b0;
      exp_acc = iv && exp_ir;
      checks++;
      if ({b_if.busy, b_if.in_ready, b_if.shift_en, b_if.win_valid} !==
          {1'b1, exp_ir, exp_acc, exp_wv}) begin
        errors++;
        $display("FAIL %s_cycle%0d: got busy/ir/sh/wv=%b want %b", tag, cyc,
                 {b_if.busy, b_if.in_ready, b_if.shift_en, b_if.win_valid},
                 {1'b1, exp_ir, exp_acc, exp_wv});
      end
      if (exp_wv) begin
        checks++;
        if (int'(b_if.win_x) != exp_x || int'(b_if.win_y) != exp_y) begin
          errors++;
          $display("FAIL %s_xy%0d: got (%0d,%0d) want (%0d,%0d)", tag, cyc,
                   b_if.win_x, b_if.win_y, exp_x, exp_y);
        end
        if (ordy) begin
          wins_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_extra_win: got (%0d,%0d) want none", tag,
                     b_if.win_x, b_if.win_y);
          end else begin
            r = exp_q.pop_front();
            if (int'(b_if.win_x) != r.x || int'(b_if.win_y) != r.y) begin
              errors++;
              $display("FAIL %s_raster: got (%0d,%0d) want (%0d,%0d)", tag,
                       b_if.win_x, b_if.win_y, r.x, r.y);
            end
          end
        end
      end
      if (b_if.frame_done === 1'b1) begin
        fd++;
        checks++;
        if (wins_seen != B_NWIN || k != B_NPIX || b_if.win_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s_early_done: got wins=%0d pix=%0d wv=%b want %0d %0d 0",
                   tag, wins_seen, k, b_if.win_valid, B_NWIN, B_NPIX);
        end
      end
      // Model update: pixel k sits at (k % BW, k / BW) in raster order.
      if (exp_acc) begin
        if ((k % BW) >= 2 && (k / BW) >= 2) begin
          exp_wv = 1'b1;
          exp_x  = (k % BW) - 1;
          exp_y  = (k / BW) - 1;
        end else if (ordy) begin
          exp_wv = 1'b0;
        end
        k++;
      end else if (ordy) begin
        exp_wv = 1'b0;
      end
      cyc++;
    end
    checks++;
    if (fd != 1 || wins_seen != B_NWIN || k != B_NPIX) begin
      errors++;
      $display("FAIL %s_totals: got fd=%0d wins=%0d pix=%0d want 1 %0d %0d", tag,
               fd, wins_seen, k, B_NWIN, B_NPIX);
    end
    step_b(1'b0, 1'b0, 1'b0);
    checks++;
    if ({b_if.busy, b_if.frame_done} !== 2'b00) begin
      errors++;
      $display("FAIL %s_after_done: got busy/fd=%b want 00", tag,
               {b_if.busy, b_if.frame_done});
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame("basic");
    test_stall();
    run_frame_b(0, "toggle");
    run_frame_b(2, "start_in_run");
    test_reset_mid();
    for (int f = 0; f < 4; f++) run_frame_b(1, "random");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 The module SHALL have parameter IMG_W, default 64, meaning the image width in pixels (legal range 3..4095).
REQ-002 The module SHALL have parameter IMG_H, default 48, meaning the image height in pixels (legal range 3..4095).
REQ-003 The module SHALL have port clk, input, 1 bit, the clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, the reset: asynchronous, active-high.
REQ-005 The module SHALL have port start, input, 1 bit, a frame-begin pulse.
REQ-006 The module SHALL have port in_valid, input, 1 bit, meaning upstream presents a pixel.
REQ-007 The module SHALL have port in_ready, output, 1 bit, meaning the controller accepts a pixel this cycle.
REQ-008 The module SHALL have port shift_en, output, 1 bit, the advance strobe to the 3-pixel row buffer chain.
REQ-009 The module SHALL have port out_ready, input, 1 bit, meaning the downstream kernel accepts a window.
REQ-010 The module SHALL have port win_valid, output, 1 bit, meaning the row buffers hold a complete 3x3 window.
REQ-011 The module SHALL have port win_x, output, 12 bits, the window-centre column.
REQ-012 The module SHALL have port win_y, output, 12 bits, the window-centre row.
REQ-013 The module SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-014 The module SHALL have port frame_done, output, 1 bit, a one-cycle end-of-frame pulse.

Function
REQ-015 The FSM SHALL have states IDLE, PRIME, RUN, DRAIN and DONE, all registered.
REQ-016 Accept SHALL be defined as in_valid & in_ready, and shift_en SHALL equal accept (combinational).
REQ-017 in_ready SHALL be 1 in PRIME; in RUN it SHALL be (!win_valid | out_ready); in IDLE, DRAIN and DONE it SHALL be 0.
REQ-018 IDLE: start=1 SHALL move to PRIME and clear col and row to 0; start in any other state SHALL be ignored.
REQ-019 On each accept, col SHALL increment; at col=IMG_W-1, col SHALL wrap to 0 and row SHALL increment.
REQ-020 PRIME SHALL move to RUN on the accept at col=IMG_W-1, row=1.
REQ-021 An accept at col>=2 and row>=2 SHALL, on the next edge, set win_valid=1, win_x=col-1 and win_y=row-1.
REQ-022 win_valid SHALL clear on an edge where out_ready=1 and no new window is produced.
REQ-023 While win_valid=1 and out_ready=0, win_valid, win_x and win_y SHALL hold, and no accept SHALL occur.
REQ-024 A new window produced in the same cycle as out_ready=1 SHALL replace the current window back-to-back, with no bubble.
REQ-025 An accept at col<2 with row>=2 SHALL produce no window; the previous window SHALL drain normally.
REQ-026 RUN SHALL move to DRAIN on the accept at col=IMG_W-1, row=IMG_H-1.
REQ-027 DRAIN SHALL move to DONE once win_valid=0, or on the edge where win_valid & out_ready.
REQ-028 DONE SHALL assert frame_done for exactly one cycle and then return to IDLE.
REQ-029 The block SHALL produce exactly (IMG_W-2)*(IMG_H-2) windows per frame, in raster order.
REQ-030 Counters SHALL be 12 bits wide, and arithmetic SHALL never wrap past IMG_W-1 or IMG_H-1.

Reset
REQ-031 On reset the block SHALL enter IDLE with col=0, row=0, win_valid=0, win_x=0, win_y=0, frame_done=0, busy=0, in_ready=0 and shift_en=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately, and no frame_done SHALL be emitted.
REQ-033 After reset deassertion, the block SHALL wait in IDLE for start.

Verification
REQ-034 Scenario: IMG_W=4, IMG_H=3, start, in_valid=1, out_ready=1 constantly -> 12 accepts; win_valid exactly 2 cycles, the cycles after accepts 11 and 12, with (x,y)=(1,1),(2,1); then frame_done is pulsed once; busy falls.
REQ-035 Scenario: same frame with out_ready=0 from accept 11 onward for 5 cycles -> win (1,1) held 5 cycles, in_ready=0, and no shift_en during the stall; then (2,1) follows normally.
REQ-036 Scenario: in_valid toggling 1/0 every cycle, IMG_W=5, IMG_H=4 -> 6 windows in raster order (1,1)..(3,2); counters unchanged on idle cycles.
REQ-037 Scenario: start pulsed in RUN -> ignored, with no counter reset and the window count unchanged.
REQ-038 Scenario: reset asserted at accept 7 of a 4x3 frame -> all outputs are immediately at reset values and there is no frame_done; a subsequent start runs a full clean frame.
